alarm_controller: RTL and testbench
===================================

ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 SHALL have parameter SNOOZE_SEC, default 300, meaning the snooze duration in SEC_TICK pulses (1..1023).
REQ-002 SHALL have parameter RING_MAX_SEC, default 600, meaning the auto-stop ring duration in SEC_TICK pulses (1..1023).
REQ-003 SHALL have port CLK  input  1  sole clock, rising edge; all inputs are synchronous to CLK.
REQ-004 SHALL have port CLR  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports SECONDS/MINUTES/HOURS  input  6/6/5  current time from the clock counter.
REQ-006 SHALL have port SEC_TICK  input  1  one-cycle pulse in the cycle the SECONDS value is new.
REQ-007 SHALL have ports ALM_SET, ALM_EN  input  1 each  alarm-setup mode level; alarm-armed level.
REQ-008 SHALL have ports MIN_ADV, HR_ADV, SNOOZE, STOP  input  1 each  button levels, acted on at the rising edge only.
REQ-009 SHALL have ports ALM_MINUTES/ALM_HOURS  output  6/5  stored alarm time.
REQ-010 SHALL have ports BUZZER  output  1  and ALM_STATE  output  2  current FSM state encoding.

Function
REQ-011 SHALL detect button edges as current=1 AND previous-cycle=0, with the edge applied one cycle after the input rises.
REQ-012 SHALL, while ALM_SET=1, increment ALM_MINUTES on each MIN_ADV edge, wrapping 59->0 with no carry into hours.
REQ-013 SHALL, while ALM_SET=1, increment ALM_HOURS on each HR_ADV edge, wrapping 23->0; simultaneous MIN_ADV and HR_ADV edges both apply.
REQ-014 SHALL ignore MIN_ADV and HR_ADV while ALM_SET=0.
REQ-015 SHALL implement FSM states IDLE=0, RINGING=1, SNOOZED=2, DONE=3, reported on ALM_STATE.
REQ-016 SHALL, in any state, go to IDLE next cycle when ALM_SET=1 or ALM_EN=0.
REQ-017 SHALL go IDLE->RINGING when ALM_EN=1, ALM_SET=0, SEC_TICK=1, SECONDS=0, MINUTES=ALM_MINUTES and HOURS=ALM_HOURS.
REQ-018 SHALL, on entering RINGING, load the ring counter with RING_MAX_SEC; the counter decrements on each SEC_TICK, and RINGING->DONE when it reaches 0.
REQ-019 SHALL take RINGING->DONE on a STOP edge, and RINGING->SNOOZED on a SNOOZE edge while loading the snooze counter with SNOOZE_SEC.
REQ-020 SHALL, in SNOOZED, decrement the snooze counter on each SEC_TICK, and SNOOZED->RINGING when it reaches 0, reloading the ring counter.
REQ-021 SHALL take SNOOZED->DONE on a STOP edge; SNOOZE edges in SNOOZED are ignored.
REQ-022 SHALL give a STOP edge priority over a SNOOZE edge or counter expiry in the same cycle.
REQ-023 SHALL take DONE->IDLE only when (HOURS,MINUTES) differs from (ALM_HOURS,ALM_MINUTES), preventing a retrigger within the match minute.
REQ-024 SHALL drive BUZZER registered, equal to 1 exactly while the state is RINGING (same cycle as ALM_STATE=1).
REQ-025 SHALL use saturating-free 10-bit counters; parameter values outside 1..1023 are illegal.

Reset
REQ-026 SHALL, on CLR=1, immediately set state IDLE, BUZZER=0, ALM_MINUTES=0, ALM_HOURS=0, both counters=0 and all edge-detect history registers=0.
REQ-027 SHALL, after CLR deasserts mid-ring, remain in IDLE until the next REQ-017 match.

Configuration
REQ-028 SHALL use macro ALARM_SNOOZE_EN: when it is defined, the SNOOZE input and SNOOZED state behave per REQ-019..021.
REQ-029 SHALL, when ALARM_SNOOZE_EN is undefined, ignore SNOOZE, never reach SNOOZED, omit the snooze counter, and leave the port present.

Structure
REQ-030 SHALL take from shared package alarm_pkg the state encoding type, MAX_MINUTE=59, MAX_HOUR=23 and the counter width 10.
REQ-031 SHALL use sub-module alarm_edge_detect (1-bit rising-edge detector, async CLR) instantiated once per button.

Verification
REQ-032 SHALL cover: CLR; ALM_SET=1; 7 MIN_ADV edges and 6 HR_ADV edges -> ALM_MINUTES=7, ALM_HOURS=6.
REQ-033 SHALL cover: ALM_MINUTES=59 plus one MIN_ADV edge -> 0 with ALM_HOURS unchanged; ALM_HOURS=23 plus one HR_ADV edge -> 0.
REQ-034 SHALL cover: alarm 06:07, ALM_EN=1, time reaches 06:07:00 with SEC_TICK -> next cycle ALM_STATE=1, BUZZER=1; STOP -> DONE; still 06:07:30 -> stays DONE; 06:08:00 -> IDLE.
REQ-035 SHALL cover: SNOOZE_SEC=3 while RINGING, SNOOZE edge -> SNOOZED, BUZZER=0; 3 SEC_TICKs later -> RINGING, BUZZER=1.
REQ-036 SHALL cover: RING_MAX_SEC=4 with no buttons -> DONE after the 4th SEC_TICK; STOP and SNOOZE in the same cycle -> DONE.
REQ-037 SHALL cover: CLR pulse while RINGING -> BUZZER=0 and ALM_STATE=0 without waiting for a clock edge; ALM_EN=0 while RINGING -> IDLE next cycle.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and limits for the alarm controller.
// State encoding, time wrap limits and ring/snooze counter width.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZED = 2'd2,
    ST_DONE    = 2'd3
  } alm_state_e;

  localparam int MAX_MINUTE = 59;
  localparam int MAX_HOUR   = 23;
  localparam int CNT_W      = 10;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic logic [5:0] inc_minute(input logic [5:0] v);
    return (v >= 6'(MAX_MINUTE)) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc_hour(input logic [4:0] v);
    return (v >= 5'(MAX_HOUR)) ? 5'd0 : v + 5'd1;
  endfunction

endpackage

// File: rtl/alarm_edge_detect.sv
// Single-bit rising-edge detector for a button level.
// The pulse is high in the cycle the level is 1 and was 0 the cycle before.
module alarm_edge_detect (
  input  logic CLK,
  input  logic CLR,
  input  logic din,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = din;
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = din & ~prev_q;

endmodule

// File: rtl/alarm_controller.sv
// Alarm clock controller: alarm time setup, ring/snooze/done FSM, buzzer.
// Define ALARM_SNOOZE_EN to enable the SNOOZE button and SNOOZED state.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int SNOOZE_SEC   = 300,
  parameter int RING_MAX_SEC = 600
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [5:0] SECONDS,
  input  logic [5:0] MINUTES,
  input  logic [4:0] HOURS,
  input  logic       SEC_TICK,
  input  logic       ALM_SET,
  input  logic       ALM_EN,
  input  logic       MIN_ADV,
  input  logic       HR_ADV,
  input  logic       SNOOZE,
  input  logic       STOP,
  output logic [5:0] ALM_MINUTES,
  output logic [4:0] ALM_HOURS,
  output logic       BUZZER,
  output logic [1:0] ALM_STATE
);

  localparam cnt_t RING_LOAD = cnt_t'(RING_MAX_SEC);

  logic min_e;
  logic hr_e;
  logic snooze_e;
  logic stop_e;

  alarm_edge_detect u_min_ed (
    .CLK  (CLK),
    .CLR  (CLR),
    .din  (MIN_ADV),
    .rise (min_e)
  );

  alarm_edge_detect u_hr_ed (
    .CLK  (CLK),
    .CLR  (CLR),
    .din  (HR_ADV),
    .rise (hr_e)
  );

  alarm_edge_detect u_snz_ed (
    .CLK  (CLK),
    .CLR  (CLR),
    .din  (SNOOZE),
    .rise (snooze_e)
  );

  alarm_edge_detect u_stop_ed (
    .CLK  (CLK),
    .CLR  (CLR),
    .din  (STOP),
    .rise (stop_e)
  );

  alm_state_e state_q, state_d;
  cnt_t       ring_q, ring_d;
  logic [5:0] alm_min_q, alm_min_d;
  logic [4:0] alm_hr_q, alm_hr_d;
  logic       buzzer_q, buzzer_d;

`ifdef ALARM_SNOOZE_EN
  localparam cnt_t SNZ_LOAD = cnt_t'(SNOOZE_SEC);
  cnt_t snz_q, snz_d;
`else
  logic snooze_unused;
  assign snooze_unused = snooze_e;
`endif

  logic time_match;
  logic alarm_hit;

  assign time_match = (MINUTES == alm_min_q) &&
                      (HOURS == alm_hr_q);
  assign alarm_hit  = SEC_TICK && (SECONDS == 6'd0) &&
                      time_match;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q   <= ST_IDLE;
      ring_q    <= '0;
      alm_min_q <= '0;
      alm_hr_q  <= '0;
      buzzer_q  <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ring_q    <= ring_d;
      alm_min_q <= alm_min_d;
      alm_hr_q  <= alm_hr_d;
      buzzer_q  <= buzzer_d;
`ifdef ALARM_SNOOZE_EN
      snz_q     <= snz_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
`ifdef ALARM_SNOOZE_EN
    snz_d   = snz_q;
`endif
    if (ALM_SET || !ALM_EN) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (alarm_hit) begin
            state_d = ST_RINGING;
            ring_d  = RING_LOAD;
          end
        end
        ST_RINGING: begin
          // STOP wins, then SNOOZE, then ring timeout
          if (stop_e) begin
            state_d = ST_DONE;
          end
`ifdef ALARM_SNOOZE_EN
          else if (snooze_e) begin
            state_d = ST_SNOOZED;
            snz_d   = SNZ_LOAD;
          end
`endif
          else if (SEC_TICK) begin
            ring_d = ring_q - cnt_t'(1);
            if (ring_q <= cnt_t'(1)) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_SNOOZED: begin
`ifdef ALARM_SNOOZE_EN
          if (stop_e) begin
            state_d = ST_DONE;
          end else if (SEC_TICK) begin
            snz_d = snz_q - cnt_t'(1);
            if (snz_q <= cnt_t'(1)) begin
              state_d = ST_RINGING;
              ring_d  = RING_LOAD;
            end
          end
`else
          state_d = ST_IDLE;
`endif
        end
        ST_DONE: begin
          // hold until the match minute has passed
          if (!time_match) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    alm_min_d = alm_min_q;
    alm_hr_d  = alm_hr_q;
    if (ALM_SET && min_e) begin
      alm_min_d = inc_minute(alm_min_q);
    end
    if (ALM_SET && hr_e) begin
      alm_hr_d = inc_hour(alm_hr_q);
    end
  end

  always_comb begin
    buzzer_d = (state_d == ST_RINGING);
  end

  assign ALM_MINUTES = alm_min_q;
  assign ALM_HOURS   = alm_hr_q;
  assign BUZZER      = buzzer_q;
  assign ALM_STATE   = state_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Scoreboard bench for alarm_controller with a cycle-level reference model.
// Honours ALARM_SNOOZE_EN to select snooze expectations.
module tb_alarm_controller;

  localparam int SNZ  = 3;
  localparam int RING = 4;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ_ON = 1'b1;
`else
  localparam bit SNZ_ON = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       CLR;
  logic [5:0] SECONDS;
  logic [5:0] MINUTES;
  logic [4:0] HOURS;
  logic       SEC_TICK;
  logic       ALM_SET;
  logic       ALM_EN;
  logic       MIN_ADV;
  logic       HR_ADV;
  logic       SNOOZE;
  logic       STOP;
  logic [5:0] ALM_MINUTES;
  logic [4:0] ALM_HOURS;
  logic       BUZZER;
  logic [1:0] ALM_STATE;

  alarm_controller #(
    .SNOOZE_SEC   (SNZ),
    .RING_MAX_SEC (RING)
  ) dut (
    .CLK         (CLK),
    .CLR         (CLR),
    .SECONDS     (SECONDS),
    .MINUTES     (MINUTES),
    .HOURS       (HOURS),
    .SEC_TICK    (SEC_TICK),
    .ALM_SET     (ALM_SET),
    .ALM_EN      (ALM_EN),
    .MIN_ADV     (MIN_ADV),
    .HR_ADV      (HR_ADV),
    .SNOOZE      (SNOOZE),
    .STOP        (STOP),
    .ALM_MINUTES (ALM_MINUTES),
    .ALM_HOURS   (ALM_HOURS),
    .BUZZER      (BUZZER),
    .ALM_STATE   (ALM_STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int st;
    int bz;
    int am;
    int ah;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // reference model: alarm time, mode, seconds left in ring/snooze
  int m_st, m_ring, m_snz, m_am, m_ah;
  bit p_min, p_hr, p_snz, p_stop;

  task automatic model_reset();
    m_st = 0; m_ring = 0; m_snz = 0;
    m_am = 0; m_ah = 0;
    p_min = 0; p_hr = 0; p_snz = 0; p_stop = 0;
  endtask

  task automatic model_step();
    bit e_min, e_hr, e_snz, e_stop, match;
    exp_t e;
    e_min  = MIN_ADV && !p_min;
    e_hr   = HR_ADV && !p_hr;
    e_snz  = SNOOZE && !p_snz;
    e_stop = STOP && !p_stop;
    p_min = MIN_ADV; p_hr = HR_ADV;
    p_snz = SNOOZE;  p_stop = STOP;
    match = (int'(MINUTES) == m_am) && (int'(HOURS) == m_ah);
    if (ALM_SET || !ALM_EN) begin
      m_st = 0;
    end else if (m_st == 0) begin
      if (SEC_TICK && SECONDS == 0 && match) begin
        m_st = 1; m_ring = RING;
      end
    end else if (m_st == 1) begin
      if (e_stop) m_st = 3;
      else if (SNZ_ON && e_snz) begin
        m_st = 2; m_snz = SNZ;
      end else if (SEC_TICK) begin
        m_ring = m_ring - 1;
        if (m_ring == 0) m_st = 3;
      end
    end else if (m_st == 2) begin
      if (e_stop) m_st = 3;
      else if (SEC_TICK) begin
        m_snz = m_snz - 1;
        if (m_snz == 0) begin
          m_st = 1; m_ring = RING;
        end
      end
    end else begin
      if (!match) m_st = 0;
    end
    if (ALM_SET && e_min) m_am = (m_am + 1) % 60;
    if (ALM_SET && e_hr)  m_ah = (m_ah + 1) % 24;
    e.st = m_st;
    e.bz = (m_st == 1) ? 1 : 0;
    e.am = m_am;
    e.ah = m_ah;
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (ALM_STATE !== 2'(e.st) || BUZZER !== 1'(e.bz) ||
            ALM_MINUTES !== 6'(e.am) || ALM_HOURS !== 5'(e.ah)) begin
          errors++;
          $display("FAIL sb cyc=%0d got st=%0d bz=%0d am=%0d ah=%0d want st=%0d bz=%0d am=%0d ah=%0d",
                   cyc, ALM_STATE, BUZZER, ALM_MINUTES, ALM_HOURS,
                   e.st, e.bz, e.am, e.ah);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  task automatic step();
    model_step();
    @(negedge CLK);
  endtask

  task automatic press(input int which);
    case (which)
      0: MIN_ADV = 1'b1;
      1: HR_ADV  = 1'b1;
      2: SNOOZE  = 1'b1;
      3: STOP    = 1'b1;
      default: begin
        MIN_ADV = 1'b1;
        HR_ADV  = 1'b1;
      end
    endcase
    step();
    MIN_ADV = 1'b0; HR_ADV = 1'b0;
    SNOOZE  = 1'b0; STOP   = 1'b0;
    step();
  endtask

  task automatic tick_at(input int h, input int m, input int s);
    HOURS = 5'(h); MINUTES = 6'(m); SECONDS = 6'(s);
    SEC_TICK = 1'b1;
    step();
    SEC_TICK = 1'b0;
    step();
  endtask

  initial begin
    CLR = 1'b1;
    SECONDS = '0; MINUTES = '0; HOURS = '0;
    SEC_TICK = 0; ALM_SET = 0; ALM_EN = 0;
    MIN_ADV = 0; HR_ADV = 0; SNOOZE = 0; STOP = 0;
    model_reset();
    repeat (2) @(negedge CLK);
    chk("rst_state", 32'(ALM_STATE), 0);
    chk("rst_buzzer", 32'(BUZZER), 0);
    chk("rst_alm_min", 32'(ALM_MINUTES), 0);
    CLR = 1'b0;

    ALM_SET = 1'b1;
    for (int i = 0; i < 7; i++) press(0);
    for (int i = 0; i < 6; i++) press(1);
    chk("set_min7", 32'(ALM_MINUTES), 7);
    chk("set_hr6", 32'(ALM_HOURS), 6);

    for (int i = 0; i < 52; i++) press(0);
    chk("min59", 32'(ALM_MINUTES), 59);
    press(0);
    chk("min_wrap", 32'(ALM_MINUTES), 0);
    chk("min_wrap_hr", 32'(ALM_HOURS), 6);
    for (int i = 0; i < 17; i++) press(1);
    chk("hr23", 32'(ALM_HOURS), 23);
    press(1);
    chk("hr_wrap", 32'(ALM_HOURS), 0);
    for (int i = 0; i < 6; i++) press(4);
    press(0);
    chk("both_min", 32'(ALM_MINUTES), 7);
    chk("both_hr", 32'(ALM_HOURS), 6);

    ALM_SET = 1'b0;
    MIN_ADV = 1'b1;
    step();
    MIN_ADV = 1'b0;
    step();
    chk("adv_ignored", 32'(ALM_MINUTES), 7);

    ALM_EN = 1'b1;
    tick_at(6, 6, 59);
    chk("pre_match", 32'(ALM_STATE), 0);
    tick_at(6, 7, 0);
    chk("ring_state", 32'(ALM_STATE), 1);
    chk("ring_buzz", 32'(BUZZER), 1);
    press(3);
    chk("stop_done", 32'(ALM_STATE), 3);
    tick_at(6, 7, 30);
    chk("done_hold", 32'(ALM_STATE), 3);
    tick_at(6, 8, 0);
    chk("done_idle", 32'(ALM_STATE), 0);

    tick_at(6, 7, 0);
    press(2);
    chk("snz_state", 32'(ALM_STATE), SNZ_ON ? 2 : 1);
    chk("snz_buzz", 32'(BUZZER), SNZ_ON ? 0 : 1);
    for (int s = 1; s <= 3; s++) tick_at(6, 7, s);
    chk("snz_ring", 32'(ALM_STATE), 1);
    chk("snz_ring_bz", 32'(BUZZER), 1);
    press(3);
    tick_at(6, 8, 0);

    tick_at(6, 7, 0);
    for (int s = 1; s <= 3; s++) tick_at(6, 7, s);
    chk("ring_3tick", 32'(ALM_STATE), 1);
    tick_at(6, 7, 4);
    chk("ring_timeout", 32'(ALM_STATE), 3);
    tick_at(6, 8, 0);

    tick_at(6, 7, 0);
    SNOOZE = 1'b1;
    STOP   = 1'b1;
    step();
    SNOOZE = 1'b0;
    STOP   = 1'b0;
    step();
    chk("stop_prio", 32'(ALM_STATE), 3);
    tick_at(6, 8, 0);

    tick_at(6, 7, 0);
    chk("ring_again", 32'(BUZZER), 1);
    CLR = 1'b1;
    #1;
    chk("clr_buzz", 32'(BUZZER), 0);
    chk("clr_state", 32'(ALM_STATE), 0);
    chk("clr_hr", 32'(ALM_HOURS), 0);
    #2;
    CLR = 1'b0;
    model_reset();
    @(negedge CLK);
    tick_at(6, 7, 0);
    chk("post_clr_idle", 32'(ALM_STATE), 0);
    tick_at(0, 0, 0);
    chk("zero_ring", 32'(ALM_STATE), 1);
    ALM_EN = 1'b0;
    step();
    chk("en_off_idle", 32'(ALM_STATE), 0);
    chk("en_off_buzz", 32'(BUZZER), 0);
    ALM_EN = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      ALM_SET  = ($urandom % 24) == 0;
      ALM_EN   = ($urandom % 30) != 0;
      MIN_ADV  = ($urandom % 4) == 0;
      HR_ADV   = ($urandom % 4) == 0;
      SNOOZE   = ($urandom % 6) == 0;
      STOP     = ($urandom % 10) == 0;
      SEC_TICK = ($urandom % 3) == 0;
      if (SEC_TICK) begin
        HOURS   = 5'(($urandom % 3 != 0) ? m_ah : $urandom_range(0, 23));
        MINUTES = 6'(($urandom % 3 != 0) ? m_am :
                     ($urandom % 2 != 0) ? (m_am + 1) % 60 :
                     $urandom_range(0, 59));
        SECONDS = 6'(($urandom % 2 != 0) ? 0 : $urandom_range(1, 59));
      end
      step();
    end

    ALM_SET = 0; MIN_ADV = 0; HR_ADV = 0;
    SNOOZE = 0; STOP = 0; SEC_TICK = 0;
    step();
    step();
    @(posedge CLK);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
